// File: rtl/dft_stage_seq.sv
// dft_stage_seq: time-multiplexed radix-2 DIF butterfly stage with frame handshake.
// Define DFT_STAGE_SCALE_EN to halve both butterfly outputs (per-stage 1/2 scaling).
//
// state | meaning
// IDLE  | waiting for an input frame, in_ready high
// RUN   | issuing twiddle addresses, one butterfly group per cycle
// FLUSH | last ROM return being written
// DONE  | output frame presented until out_ready
module dft_stage_seq #(
  parameter int fix_bit  = 7,
  parameter int bits     = 16,
  parameter int N_POINTS = 32,
  parameter int LANES    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_POINTS*2*bits-1:0]            in_frame,
  output logic [LANES*$clog2(N_POINTS/2)-1:0]   tw_addr,
  input  logic [LANES*2*bits-1:0]               tw_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N_POINTS*2*bits-1:0]            out_frame,
  output logic                                  sat_flag,
  output logic                                  busy
);

  localparam int HALF = N_POINTS / 2;
  localparam int C    = N_POINTS / (2 * LANES);
  localparam int AW   = $clog2(HALF);
  localparam int GW   = (C > 1) ? $clog2(C) : 1;
  localparam int W2   = 2 * bits;
  localparam int PW   = 2 * bits + 2;
  localparam logic [bits-2:0] MAX_MAG = '1;

  if (N_POINTS < 4 || (N_POINTS & (N_POINTS - 1)) != 0 || LANES < 1 ||
      (LANES & (LANES - 1)) != 0 || (N_POINTS / 2) % LANES != 0 ||
      bits < 2 || fix_bit < 0 || fix_bit >= bits) begin : g_bad_cfg
    $error("dft_stage_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                    state, state_nx;
  logic [GW-1:0]             g, g_d;
  logic                      wr_en;
  logic [N_POINTS*W2-1:0]    x_buf;
  logic [W2-1:0]             y_top [LANES];
  logic [W2-1:0]             y_bot [LANES];
  logic [LANES-1:0]          sat_lane;

  function automatic logic signed [PW-1:0] sm2tc(input logic [bits-1:0] v);
    logic signed [PW-1:0] m;
    m = signed'(PW'(v[bits-2:0]));
    return v[bits-1] ? -m : m;
  endfunction

  // Returns {clipped, sign, magnitude}; zero magnitude always carries a + sign.
  function automatic logic [bits:0] tc2sm(input logic signed [PW-1:0] v, input int sh);
    logic [PW-1:0] mag;
    logic          neg;
    logic          sat;
    neg = v[PW-1];
    mag = neg ? -v : v;
    if (sh > 0) mag = (mag + (PW'(1) << (sh - 1))) >> sh;
`ifdef DFT_STAGE_SCALE_EN
    mag = (mag + PW'(1)) >> 1;
`endif
    sat = mag > PW'(MAX_MAG);
    if (sat) mag = PW'(MAX_MAG);
    if (mag == '0) neg = 1'b0;
    return {sat, neg, mag[bits-2:0]};
  endfunction

  function automatic logic [2*W2:0] bfly(input logic [W2-1:0] a, input logic [W2-1:0] b,
                                         input logic [W2-1:0] w);
    logic signed [PW-1:0] sr, si, dr, di, wr, wi, pr, pi;
    logic [bits:0]        t_r, t_i, b_r, b_i;
    sr  = sm2tc(a[bits-1:0]) + sm2tc(b[bits-1:0]);
    si  = sm2tc(a[W2-1:bits]) + sm2tc(b[W2-1:bits]);
    dr  = sm2tc(a[bits-1:0]) - sm2tc(b[bits-1:0]);
    di  = sm2tc(a[W2-1:bits]) - sm2tc(b[W2-1:bits]);
    wr  = sm2tc(w[bits-1:0]);
    wi  = sm2tc(w[W2-1:bits]);
    pr  = dr * wr - di * wi;
    pi  = dr * wi + di * wr;
    t_r = tc2sm(sr, 0);
    t_i = tc2sm(si, 0);
    b_r = tc2sm(pr, fix_bit);
    b_i = tc2sm(pi, fix_bit);
    return {t_r[bits] | t_i[bits] | b_r[bits] | b_i[bits],
            t_i[bits-1:0], t_r[bits-1:0], b_i[bits-1:0], b_r[bits-1:0]};
  endfunction

  // g_d is the group whose twiddles arrive this cycle.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      {sat_lane[l], y_top[l], y_bot[l]} =
        bfly(x_buf[(l*C + int'(g_d))*W2 +: W2],
             x_buf[(l*C + int'(g_d) + HALF)*W2 +: W2],
             tw_data[l*W2 +: W2]);
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    tw_addr   = '0;
    case (state)
      IDLE: begin
        in_ready = reset;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) tw_addr[l*AW +: AW] = AW'(l*C) + AW'(g);
        if (g == GW'(C - 1)) state_nx = FLUSH;
      end
      FLUSH: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      g         <= '0;
      g_d       <= '0;
      wr_en     <= 1'b0;
      x_buf     <= '0;
      out_frame <= '0;
      sat_flag  <= 1'b0;
    end else begin
      state <= state_nx;
      g_d   <= g;
      wr_en <= (state == RUN);
      if (state == IDLE && in_valid) begin
        x_buf    <= in_frame;
        sat_flag <= 1'b0;
        g        <= '0;
      end else if (state == RUN) begin
        g <= (g == GW'(C - 1)) ? '0 : g + 1'b1;
      end
      if (wr_en) begin
        for (int l = 0; l < LANES; l++) begin
          out_frame[(l*C + int'(g_d))*W2 +: W2]        <= y_top[l];
          out_frame[(l*C + int'(g_d) + HALF)*W2 +: W2] <= y_bot[l];
        end
        if (|sat_lane) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dft_stage_seq.sv
// Directed bench for dft_stage_seq (N=32, 4 lanes): hand-computed frames,
// latency, twiddle addressing, saturation, reset and handshake behaviour.
module tb_dft_stage_seq;

  localparam int FB  = 7;
  localparam int BITS = 16;
  localparam int NP  = 32;
  localparam int LN  = 4;
  localparam int AWB = 4;
  localparam int FW  = NP * 2 * BITS;
  localparam int TWW = LN * AWB;
`ifdef DFT_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FW-1:0]   in_frame = '0;
  logic [TWW-1:0]  tw_addr;
  logic [LN*2*BITS-1:0] tw_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [FW-1:0]   out_frame;
  logic            sat_flag;
  logic            busy;

  logic [31:0]     rom [0:15];
  logic [TWW-1:0]  tw_trace [0:7];
  logic [FW-1:0]   fr, ex, imp_fr, imp_ex;
  logic [TWW-1:0]  e_tw;
  int              n_checks = 0;
  int              n_fail = 0;

  dft_stage_seq #(.fix_bit(FB), .bits(BITS), .N_POINTS(NP), .LANES(LN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_frame(in_frame), .tw_addr(tw_addr), .tw_data(tw_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous twiddle ROM, one read port per lane.
  always @(posedge clk) begin
    for (int l = 0; l < LN; l++) tw_data[l*32 +: 32] <= rom[tw_addr[l*AWB +: AWB]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [FW-1:0] exp);
    for (int k = 0; k < NP; k++)
      check($sformatf("%s_pt%0d", tag, k), 64'(out_frame[k*32 +: 32]), 64'(exp[k*32 +: 32]));
  endtask

  task automatic run_frame(input string tag, input logic [FW-1:0] f);
    int t;
    int lat;
    for (int i = 0; i < 8; i++) tw_trace[i] = '1;
    @(negedge clk);
    in_frame = f;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat < 8) tw_trace[lat] = tw_addr;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'd6);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int hs [$];
    int cyc;

    rom[0]  = 32'h00000080; rom[1]  = 32'h8018007D; rom[2]  = 32'h80300076; rom[3]  = 32'h8047006A;
    rom[4]  = 32'h805A005A; rom[5]  = 32'h806A0047; rom[6]  = 32'h80760030; rom[7]  = 32'h807D0018;
    rom[8]  = 32'h80800000; rom[9]  = 32'h807D8018; rom[10] = 32'h80768030; rom[11] = 32'h806A8047;
    rom[12] = 32'h805A805A; rom[13] = 32'h8047806A; rom[14] = 32'h80308076; rom[15] = 32'h8018807D;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_tw_addr", 64'(tw_addr), 64'd0);
    check_frame("rst_out", '0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Impulse
    imp_fr = '0;
    imp_fr[0*32 +: 32] = 32'h00000080;
    imp_ex = '0;
    imp_ex[0*32 +: 32]  = SCALE ? 32'h00000040 : 32'h00000080;
    imp_ex[16*32 +: 32] = SCALE ? 32'h00000040 : 32'h00000080;
    run_frame("imp", imp_fr);
    check_frame("imp", imp_ex);
    check("imp_sat", 64'(sat_flag), 64'd0);
    check("imp_busy", 64'(busy), 64'd1);
    for (int g = 0; g < 4; g++) begin
      e_tw = '0;
      for (int l = 0; l < LN; l++) e_tw[l*AWB +: AWB] = 4'(l*4 + g);
      check($sformatf("tw_addr_c%0d", g + 1), 64'(tw_trace[g+1]), 64'(e_tw));
    end
    check("tw_addr_flush", 64'(tw_trace[5]), 64'd0);
    pop();

    // Constant frame, then backpressure with a competing frame offered in DONE
    for (int k = 0; k < NP; k++) fr[k*32 +: 32] = 32'h00000080;
    ex = '0;
    for (int k = 0; k < 16; k++) ex[k*32 +: 32] = SCALE ? 32'h00000080 : 32'h00000100;
    run_frame("const", fr);
    check_frame("const", ex);
    check("const_sat", 64'(sat_flag), 64'd0);
    in_frame = imp_fr;
    in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_frame !== ex) bad++;
    end
    check("bp_hold_cycles_bad", 64'(bad), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check_frame("bp_frame", ex);
    in_valid = 1'b0;
    pop();
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Twiddle path, rounding, negative differences and -0 input
    fr = '0;
    fr[1*32 +: 32]  = 32'h00000080;
    fr[3*32 +: 32]  = 32'h00000001;
    fr[5*32 +: 32]  = 32'h80008000;
    fr[20*32 +: 32] = 32'h00000080;
    ex = '0;
    ex[1*32 +: 32]  = SCALE ? 32'h00000040 : 32'h00000080;
    ex[17*32 +: 32] = SCALE ? 32'h800C003F : 32'h8018007D;
    ex[3*32 +: 32]  = 32'h00000001;
    ex[19*32 +: 32] = 32'h80010001;
    ex[4*32 +: 32]  = SCALE ? 32'h00000040 : 32'h00000080;
    ex[20*32 +: 32] = SCALE ? 32'h002D802D : 32'h005A805A;
    run_frame("tw", fr);
    check_frame("tw", ex);
    check("tw_sat", 64'(sat_flag), 64'd0);
    pop();

    // Saturation, then a clean frame clears sat_flag
    fr = '0;
    fr[0*32 +: 16]  = 16'h7FFF;
    fr[16*32 +: 16] = 16'h7FFF;
    ex = '0;
    ex[0*32 +: 32] = 32'h00007FFF;
    run_frame("sat", fr);
    check_frame("sat", ex);
    check("sat_flag_set", 64'(sat_flag), SCALE ? 64'd0 : 64'd1);
    pop();
    run_frame("clean", imp_fr);
    check("clean_sat", 64'(sat_flag), 64'd0);
    check("clean_pt0", 64'(out_frame[31:0]), 64'(imp_ex[31:0]));
    pop();

    // Reset held low 3 cycles mid-RUN
    @(negedge clk);
    check("mr_accept", 64'(in_ready), 64'd1);
    in_frame = fr;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd0);
    check("mr_sat", 64'(sat_flag), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_tw_addr", 64'(tw_addr), 64'd0);
    check_frame("mr_out", '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_rel_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("mr_no_stale_frame", 64'(bad), 64'd0);

    // Back-to-back frames with out_ready held high
    @(negedge clk);
    in_frame = imp_fr;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    repeat (30) begin
      if (in_valid && in_ready) hs.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_count", 64'(hs.size() >= 4), 64'd1);
    if (hs.size() >= 4) begin
      check("b2b_first", 64'(hs[0]), 64'd0);
      check("b2b_gap1", 64'(hs[1] - hs[0]), 64'd7);
      check("b2b_gap2", 64'(hs[2] - hs[1]), 64'd7);
      check("b2b_gap3", 64'(hs[3] - hs[2]), 64'd7);
    end
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dft_stage_seq.md
Name: dft_stage_seq

Overview:
- Parametrised, time-multiplexed radix-2 decimation-in-frequency butterfly stage. It generalises the fixed 32-point / 4-MAC first stage to any N and any lane count, with an internal sequencer, a frame handshake and saturation detection.
- Accepts one N-point complex frame and runs N/(2*LANES) butterfly groups over time, reading twiddles from an external synchronous ROM. It buffers the full output frame and presents it with valid/ready.
- Sits between the input sample capture and the next FFT stage or the output file register.

Parameters:
- fix_bit, 7, fractional bits per real/imag component.
- bits, 16, width of one component, sign-magnitude.
- N_POINTS, 32, frame length; power of two, at least 4.
- LANES, 4, butterflies per cycle; power of two, must divide N_POINTS/2.
- Derived: C = N_POINTS/(2*LANES) groups; AW = clog2(N_POINTS/2).
- Illegal combination -> $error at elaboration.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  input frame valid.
- in_ready  out  1  stage can accept a frame.
- in_frame  in  N_POINTS*2*bits  point k at [k*2*bits +: 2*bits], packed {imag,real}.
- tw_addr  out  LANES*AW  lane l twiddle index at [l*AW +: AW].
- tw_data  in  LANES*2*bits  lane l twiddle {imag,real}, sign-magnitude, returned 1 cycle after its address.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts.
- out_frame  out  N_POINTS*2*bits  same packing as in_frame.
- sat_flag  out  1  any saturation occurred in the presented frame.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset==0 at an edge) puts the block in this state:
  - FSM in IDLE, all counters 0.
  - out_frame all 0, out_valid 0, sat_flag 0, tw_addr 0, busy 0.
  - in_ready is 0 while reset is low.
- Reset mid-operation discards the frame in flight, with the same values.
- Number formats:
  - Components are sign-magnitude Q(bits-1-fix_bit).fix_bit; 1.0 = 0x0080.
  - -0 is accepted on input; +0 is always emitted.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready, capture in_frame into the input buffer, g<=0, go to RUN.
  - RUN: for lane l in group g, tw_addr lane l = l*C+g. Increment g; after g==C-1, go to FLUSH.
  - FLUSH: one cycle for the last ROM return, then go to DONE.
  - DONE: out_valid=1, out_frame and sat_flag stable. When out_ready, go to IDLE.
- in_ready is 0 outside IDLE. tw_addr is 0 outside RUN.
- Butterfly for group g, lane l:
  - k = l*C+g, a = x[k], b = x[k+N/2].
  - y[k] = a+b; y[k+N/2] = (a-b)*W, with W = tw_data lane l.
  - Both results are written to the output buffer at the edge ending the cycle after the address cycle.
- Arithmetic:
  - Sums and differences are formed at bits+1 width in two's complement internally.
  - The complex product is computed at full precision.
  - Product is shifted right by fix_bit, rounded half away from zero.
  - Every output component saturates to magnitude 2^(bits-1)-1; any clip sets sat_flag.
  - sat_flag clears when the next frame is accepted.
- Latency: the handshake happens in cycle 0 and out_valid is first high in cycle C+2. For N=32, LANES=4 that is cycle 6.
- Throughput: one frame per C+3 cycles when out_ready is held at 1.
- Simultaneous events:
  - in_valid during DONE is ignored; the frame is not accepted.
  - out_ready while not out_valid has no effect.

Optional Feature:
- Macro: DFT_STAGE_SCALE_EN.
- Defined: both butterfly outputs are additionally halved (arithmetic shift right 1, round half away from zero) before saturation. This gives per-stage 1/2 scaling, so chained stages do not overflow.
- Undefined: no scaling.
- Latency and handshake are identical in both cases.

Test Plan:
- Reset held low 3 cycles mid-RUN -> next cycle out_valid=0, in_ready=0, sat_flag=0, busy=0. After release: in_ready=1, and no stale frame is ever presented.
- Impulse: in0=0x00000080, all other points 0, ROM holds W^k -> out0=0x00000080, out16=0x00000080, all other points 0. out_valid rises in cycle 6. Lane l tw_addr sequence is l*4, l*4+1, l*4+2, l*4+3.
- Constant: all points 0x00000080 -> out0..15=0x00000100, out16..31=0. With DFT_STAGE_SCALE_EN: out0..15=0x00000080.
- Twiddle path: in1=0x00000080, all other points 0, ROM entry 1=0x8018007D -> out1=0x00000080, out17=0x8018007D, all other points 0.
- Saturation: in0 real=in16 real=0x7FFF -> out0 real=0x7FFF and sat_flag=1. The following clean frame gives sat_flag=0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid held, out_frame unchanged, in_ready=0. out_ready=1 -> in_ready=1 next cycle. Back-to-back frames with out_ready=1 are accepted every 7 cycles.
